// File: rtl/cache_arbiter_pkg.sv
// Shared types and helpers for the round-robin cache arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  // Width of the WAIT-state timeout counter; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Requester-side bus of the cache arbiter: per-requester request lanes plus shared response.
interface cache_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned AW      = 8
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_we;
  logic [NUM_REQ*AW-1:0]    req_addr;
  logic [NUM_REQ*WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_rdata;
  logic                     rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/cache_rr_pick.sv
// Combinational round-robin picker: first active request after 'last', with wrap-around.
module cache_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned LW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [LW-1:0]      last,
  output logic [LW-1:0]      grant,
  output logic               any
);

  always_comb begin
    int unsigned idx;
    logic [LW-1:0] idx_l;
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    idx_l = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx   = (32'(last) + k) % NUM_REQ;
      idx_l = LW'(idx);
      if (!any && req[idx_l]) begin
        any   = 1'b1;
        grant = idx_l;
      end
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one cache between NUM_REQ requesters: accept, strobe, wait for done/timeout, respond.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RAM_DEPTH = 256,
  parameter int unsigned TIMEOUT   = 64,
  localparam int unsigned AW       = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_arbiter_if.slave       req_bus,
  output logic                 busy,
  output logic                 cache_re,
  output logic                 cache_we,
  output logic [AW-1:0]        cache_addr,
  output logic [WIDTH-1:0]     cache_wdata,
  input  logic                 cache_done,
  input  logic [WIDTH-1:0]     cache_rdata
);

  localparam int unsigned LW = $clog2(NUM_REQ);
  localparam int unsigned CW = cnt_width(TIMEOUT);

  arb_state_t          state, state_d;
  logic [LW-1:0]       last_grant, grant;
  logic                any;
  logic                we_q;
  logic [CW-1:0]       cnt;
  logic                accept, done_ok, expire;
  logic [NUM_REQ-1:0]  grant_oh, owner_oh;

  cache_rr_pick #(.NUM_REQ(NUM_REQ), .LW(LW)) u_pick (
    .req   (req_bus.req_valid),
    .last  (last_grant),
    .grant (grant),
    .any   (any)
  );

  assign grant_oh          = NUM_REQ'(1) << grant;
  assign owner_oh          = NUM_REQ'(1) << last_grant;
  assign req_bus.req_ready = accept ? grant_oh : '0;

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    done_ok = 1'b0;
    expire  = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // done in the expiry cycle still counts as a normal completion
        if (cache_done) begin
          done_ok = 1'b1;
          state_d = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          expire  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      last_grant        <= LW'(NUM_REQ - 1);
      we_q              <= 1'b0;
      cnt               <= '0;
      busy              <= 1'b0;
      cache_re          <= 1'b0;
      cache_we          <= 1'b0;
      cache_addr        <= '0;
      cache_wdata       <= '0;
      req_bus.rsp_valid <= '0;
      req_bus.rsp_rdata <= '0;
      req_bus.rsp_err   <= 1'b0;
    end else begin
      state             <= state_d;
      busy              <= (state_d != IDLE);
      cache_re          <= 1'b0;
      cache_we          <= 1'b0;
      req_bus.rsp_valid <= '0;
      if (accept) begin
        last_grant  <= grant;
        we_q        <= req_bus.req_we[grant];
        cache_addr  <= req_bus.req_addr[grant*AW +: AW];
        cache_wdata <= req_bus.req_wdata[grant*WIDTH +: WIDTH];
        cache_re    <= ~req_bus.req_we[grant];
        cache_we    <= req_bus.req_we[grant];
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT && !done_ok && !expire) begin
        cnt <= cnt + CW'(1);
      end
      if (done_ok) begin
        req_bus.rsp_valid <= owner_oh;
        req_bus.rsp_rdata <= we_q ? '0 : cache_rdata;
        req_bus.rsp_err   <= 1'b0;
      end
      if (expire) begin
        req_bus.rsp_valid <= owner_oh;
        req_bus.rsp_rdata <= '0;
        req_bus.rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed table, reset corner cases and random traffic vs a transaction model.
module tb_cache_arbiter;

  localparam int NR    = 2;
  localparam int W     = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int TO    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy, cache_re, cache_we;
  logic [AW-1:0] cache_addr;
  logic [W-1:0]  cache_wdata;
  logic          cache_done = 1'b0;
  logic [W-1:0]  cache_rdata = '0;

  cache_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .AW(AW)) bus ();

  cache_arbiter #(.NUM_REQ(NR), .WIDTH(W), .RAM_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_bus     (bus),
    .busy        (busy),
    .cache_re    (cache_re),
    .cache_we    (cache_we),
    .cache_addr  (cache_addr),
    .cache_wdata (cache_wdata),
    .cache_done  (cache_done),
    .cache_rdata (cache_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // transaction-level reference model
  bit            txn;
  int            acc_c, rsp_c, owner, last, t_lat, next_lat;
  bit            t_we;
  logic [W-1:0]  cur_rd, prev_rd, cur_cw, prev_cw;
  logic          cur_err, prev_err;
  logic [AW-1:0] cur_ca, prev_ca;
  logic [W-1:0]  rmem [DEPTH];

  // cache behavioural model
  logic [W-1:0]  cmem [DEPTH];
  int            pend;
  bit            c_we, inject_done;
  logic [AW-1:0] c_addr;

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  we;
    logic [15:0] a;
    logic [15:0] d;
    int          lat;
    int          exp_owner;
    logic [7:0]  exp_rd;
    logic        exp_err;
    int          exp_dly;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_win(input logic [NR-1:0] v, input int lst);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (lst + k) % NR;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    txn = 0; acc_c = 0; rsp_c = 0; owner = 0; last = NR - 1; t_lat = 0; t_we = 0;
    cur_rd = '0; prev_rd = '0; cur_cw = '0; prev_cw = '0;
    cur_err = 1'b0; prev_err = 1'b0; cur_ca = '0; prev_ca = '0;
    pend = 0; inject_done = 0;
  endtask

  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] we,
                      input logic [NR*AW-1:0] a, input logic [NR*W-1:0] d,
                      output int granted);
    int win;
    bit strobe, idle, tmo;
    logic [NR-1:0] exp_ready;
    logic [AW-1:0] ad;
    @(posedge clk); #1;
    cyc++;
    cache_rdata = W'($urandom);
    cache_done  = 1'b0;
    if (inject_done) begin
      cache_done  = 1'b1;
      inject_done = 0;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        cache_done = 1'b1;
        if (!c_we) cache_rdata = cmem[c_addr];
      end
    end
    if (cache_re || cache_we) begin
      c_we   = cache_we;
      c_addr = cache_addr;
      if (cache_we) cmem[cache_addr] = cache_wdata;
      pend = t_lat;
    end
    strobe = txn && (cyc == acc_c + 1);
    chk("cache_re", 32'(cache_re), 32'(strobe && !t_we));
    chk("cache_we", 32'(cache_we), 32'(strobe && t_we));
    chk("busy", 32'(busy), 32'(txn && cyc > acc_c && cyc <= rsp_c));
    chk("rsp_valid", 32'(bus.rsp_valid), (txn && cyc == rsp_c) ? (32'(1) << owner) : 32'(0));
    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'((txn && cyc >= rsp_c) ? cur_rd : prev_rd));
    chk("rsp_err", 32'(bus.rsp_err), 32'((txn && cyc >= rsp_c) ? cur_err : prev_err));
    chk("cache_addr", 32'(cache_addr), 32'((txn && cyc > acc_c) ? cur_ca : prev_ca));
    chk("cache_wdata", 32'(cache_wdata), 32'((txn && cyc > acc_c) ? cur_cw : prev_cw));
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #1;
    idle      = !txn || (cyc > rsp_c);
    win       = idle ? rr_win(v, last) : -1;
    exp_ready = (win >= 0) ? (NR'(1) << win) : '0;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    granted = win;
    if (win >= 0) begin
      ad      = a[win*AW +: AW];
      prev_ca = cur_ca;  cur_ca = ad;
      prev_cw = cur_cw;  cur_cw = d[win*W +: W];
      prev_rd = cur_rd;  prev_err = cur_err;
      t_we    = we[win];
      t_lat   = next_lat;
      tmo     = (next_lat == 0) || (next_lat > TO);
      rsp_c   = cyc + 2 + (tmo ? TO : next_lat);
      cur_err = tmo;
      cur_rd  = (tmo || t_we) ? '0 : rmem[ad];
      if (t_we) rmem[ad] = cur_cw;
      last    = win;
      owner   = win;
      acc_c   = cyc;
      txn     = 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    cyc++;
    rst = 1'b1;
    model_reset();
    cache_done    = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_cache_re", 32'(cache_re), 0);
    chk("rst_cache_we", 32'(cache_we), 0);
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
  endtask

  task automatic run_txn(input logic [1:0] v, input logic [1:0] we, input logic [15:0] a,
                         input logic [15:0] d, input int lat, output int owner_o,
                         output logic [7:0] rd_o, output logic err_o, output int dly_o);
    int g, t_acc;
    bit done;
    logic [1:0] vv;
    vv = v; owner_o = -1; rd_o = '0; err_o = 1'b0; dly_o = -1; t_acc = -1; done = 0;
    next_lat = lat;
    for (int i = 0; i < 40 && !done; i++) begin
      step(vv, we, a, d, g);
      if (t_acc >= 0 && bus.rsp_valid != '0) begin
        chk("rsp_owner", 32'(bus.rsp_valid), 32'(1) << owner_o);
        rd_o  = bus.rsp_rdata;
        err_o = bus.rsp_err;
        dly_o = cyc - t_acc;
        done  = 1;
      end else if (t_acc < 0 && bus.req_ready != '0) begin
        t_acc = cyc;
        for (int k = 0; k < NR; k++) if (bus.req_ready[k]) owner_o = k;
        vv[owner_o] = 1'b0;
      end
    end
    bus.req_valid = vv;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL txn_budget: no response within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  vec_t tbl [7];

  initial begin
    int g, own, dly;
    logic [7:0] rd;
    logic er;
    logic [NR-1:0] hv, hwe;
    logic [NR*AW-1:0] ha;
    logic [NR*W-1:0] hd;

    tbl[0] = '{2'b01, 2'b00, {8'h00, 8'h24}, 16'h0000, 3, 0, 8'h5A, 1'b0, 5};
    tbl[1] = '{2'b10, 2'b10, {8'h80, 8'h00}, {8'hC3, 8'h00}, 2, 1, 8'h00, 1'b0, 4};
    tbl[2] = '{2'b01, 2'b00, {8'h00, 8'h80}, 16'h0000, 0, 0, 8'h00, 1'b1, 10};
    tbl[3] = '{2'b01, 2'b00, {8'h00, 8'h80}, 16'h0000, 1, 0, 8'hC3, 1'b0, 3};
    tbl[4] = '{2'b10, 2'b00, {8'h24, 8'h00}, 16'h0000, TO, 1, 8'h5A, 1'b0, 10};
    tbl[5] = '{2'b11, 2'b01, {8'h24, 8'h10}, {8'h00, 8'h77}, TO + 1, 0, 8'h00, 1'b1, 10};
    tbl[6] = '{2'b11, 2'b00, {8'h24, 8'h10}, 16'h0000, 2, 1, 8'h5A, 1'b0, 4};

    for (int i = 0; i < DEPTH; i++) begin
      rmem[i] = W'($urandom);
      cmem[i] = rmem[i];
    end
    rmem[8'h24] = 8'h5A;
    cmem[8'h24] = 8'h5A;
    bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
    next_lat = 1;
    model_reset();
    do_reset();

    // quiet period after reset
    for (int i = 0; i < 10; i++) step('0, '0, '0, '0, g);
    chk("idle_rdata", 32'(bus.rsp_rdata), 0);
    chk("idle_addr", 32'(cache_addr), 0);

    foreach (tbl[i]) begin
      run_txn(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].lat, own, rd, er, dly);
      chk("tbl_owner", 32'(own), 32'(tbl[i].exp_owner));
      chk("tbl_rdata", 32'(rd), 32'(tbl[i].exp_rd));
      chk("tbl_err", 32'(er), 32'(tbl[i].exp_err));
      chk("tbl_latency", 32'(dly), 32'(tbl[i].exp_dly));
    end

    // reset while waiting on a cache that never answers, then a stray done
    next_lat = 0;
    g = -1;
    for (int i = 0; i < 5 && g < 0; i++) step(2'b01, 2'b00, {8'h00, 8'h24}, '0, g);
    chk("wait_accept", 32'(g), 0);
    step('0, '0, '0, '0, g);
    step('0, '0, '0, '0, g);
    step('0, '0, '0, '0, g);
    do_reset();
    inject_done = 1;
    for (int i = 0; i < 5; i++) begin
      step('0, '0, '0, '0, g);
      chk("late_done_no_rsp", 32'(bus.rsp_valid), 0);
      chk("late_done_idle", 32'(busy), 0);
    end

    // simultaneous requesters alternate, starting from requester 0
    for (int i = 0; i < 6; i++) begin
      run_txn(2'b11, 2'b00, {8'h24, 8'h80}, '0, int'($urandom_range(1, 4)), own, rd, er, dly);
      chk("rr_order", 32'(own), 32'(i % 2));
      chk("rr_err", 32'(er), 0);
    end
    bus.req_valid = '0;

    // random traffic with withdrawals, timeouts and late done pulses
    hv = '0; hwe = '0; ha = '0; hd = '0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!hv[i] && $urandom_range(0, 2) == 0) begin
          hv[i] = 1'b1;
          hwe[i] = 1'($urandom);
          ha[i*AW +: AW] = AW'($urandom_range(0, 15));
          hd[i*W +: W] = W'($urandom);
        end else if (hv[i] && $urandom_range(0, 7) == 0) begin
          hv[i] = 1'b0;
        end
      end
      next_lat = int'($urandom_range(0, TO + 2));
      step(hv, hwe, ha, hd, g);
      if (g >= 0) hv[g] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench still running at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
